// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with 2-entry prefetch queue
module fetch_unit #(
    parameter int              ADDR_W   = 8,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              clr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              id_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [1:0]          count_q, count_d;
    logic                rd_ptr, wr_ptr;
    logic [ADDR_W-1:0]   fifo_pc    [2];
    logic [DATA_W-1:0]   fifo_instr [2];

    logic ack, push, pop, can_issue;

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign id_valid  = (count_q != 2'd0);
    assign id_instr  = fifo_instr[rd_ptr];
    assign id_pc     = fifo_pc[rd_ptr];

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        // acks without an outstanding request are ignored
        ack        = imem_ack & req_q;
        push       = (state_q == REQ) & ack & ~redirect;
        pop        = id_valid & id_ready & ~redirect;
        count_d    = redirect ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        can_issue  = (count_d < 2'd2);

        case (state_q)
            IDLE: begin
                if (!redirect && can_issue) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (ack) begin
                    if (redirect) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end else begin
                        fetch_pc_d = addr_q + ADDR_W'(4);
                        if (can_issue) begin
                            addr_d = addr_q + ADDR_W'(4);
                        end else begin
                            state_d = IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (redirect) begin
            fetch_pc_d = redirect_addr & ~ADDR_W'(3);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            if (redirect) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr]    <= addr_q;
                    fifo_instr[wr_ptr] <= imem_rdata;
                    wr_ptr             <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [7:0]  id_pc;
    logic        id_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_addr = '0;

    logic        w_req;
    logic [7:0]  w_addr;
    logic        w_ack = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [7:0]  w_pc;

    int n_cmp = 0;
    int n_bad = 0;
    int lat = 0;
    int wait_cnt = 0;

    fetch_unit #(.ADDR_W(8), .DATA_W(32), .RESET_PC(8'h00)) dut (
        .clk(clk), .clr(clr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_ready(id_ready), .redirect(redirect), .redirect_addr(redirect_addr)
    );

    fetch_unit #(.ADDR_W(8), .DATA_W(32), .RESET_PC(8'hF8)) u_wrap (
        .clk(clk), .clr(clr),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .id_valid(w_valid), .id_instr(w_instr), .id_pc(w_pc),
        .id_ready(1'b1), .redirect(1'b0), .redirect_addr(8'h00)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [7:0] a);
        return {a, ~a, 8'h5A, a ^ 8'h3C};
    endfunction

    // memory for the main instance: ack arrives lat+1 cycles after the request is seen
    always @(posedge clk) begin
        #1;
        if (clr || !imem_req) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = word(imem_addr);
            wait_cnt   = 0;
        end else begin
            imem_ack = 1'b0;
            wait_cnt = wait_cnt + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        w_ack   = w_req && !clr;
        w_rdata = word(w_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic       ready;
        logic       redir;
        logic [7:0] raddr;
        logic       req;
        logic [7:0] addr;
        logic       valid;
        logic [7:0] pc;
    } vec_t;

    vec_t       vecs [16];
    logic [7:0] w_exp_addr [5];
    logic [7:0] w_exp_pc   [5];

    initial begin
        int n;
        logic [7:0] exp_pc;

        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 8'h04};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h0C, 1'b1, 8'h08};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 1'b1, 8'h0C};
        vecs[7]  = '{1'b1, 1'b1, 8'h20, 1'b0, 8'h10, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h24, 1'b1, 8'h20};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h28, 1'b1, 8'h24};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h28, 1'b1, 8'h24};
        vecs[12] = '{1'b0, 1'b1, 8'h83, 1'b0, 8'h28, 1'b0, 8'h00};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 8'h00};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h84, 1'b1, 8'h80};
        vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h88, 1'b1, 8'h84};
        w_exp_addr = '{8'hF8, 8'hFC, 8'h00, 8'h04, 8'h08};
        w_exp_pc   = '{8'h00, 8'hF8, 8'hFC, 8'h00, 8'h04};

        #12;
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 8'h00);
        check("rst_valid", id_valid, 1'b0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_pc", id_pc, 8'h00);
        check("rst_wrap_addr", w_addr, 8'hF8);
        clr = 1'b0;

        for (int i = 0; i < 16; i++) begin
            id_ready      = vecs[i].ready;
            redirect      = vecs[i].redir;
            redirect_addr = vecs[i].raddr;
            tick();
            redirect = 1'b0;
            check($sformatf("v%0d_req", i), imem_req, vecs[i].req);
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("v%0d_valid", i), id_valid, vecs[i].valid);
            if (vecs[i].valid) begin
                check($sformatf("v%0d_pc", i), id_pc, vecs[i].pc);
                check($sformatf("v%0d_instr", i), id_instr, word(vecs[i].pc));
            end
            if (i < 5) begin
                check($sformatf("w%0d_addr", i), w_addr, w_exp_addr[i]);
                check($sformatf("w%0d_valid", i), w_valid, i > 0);
                if (i > 0) begin
                    check($sformatf("w%0d_pc", i), w_pc, w_exp_pc[i]);
                    check($sformatf("w%0d_instr", i), w_instr, word(w_exp_pc[i]));
                end
            end
        end

        // asynchronous clear while a request is outstanding
        clr = 1'b1;
        #1;
        check("aclr_req", imem_req, 1'b0);
        check("aclr_valid", id_valid, 1'b0);
        check("aclr_addr", imem_addr, 8'h00);
        tick();
        lat = 3;
        id_ready = 1'b1;
        #3;
        clr = 1'b0;
        tick();
        check("restart_req", imem_req, 1'b1);
        check("restart_addr", imem_addr, 8'h00);

        // slow memory: stream until request for 0x08 is issued
        exp_pc = 8'h00;
        n = 0;
        while (!(imem_req && imem_addr == 8'h08) && n < 30) begin
            if (id_valid) begin
                check("slow_pc", id_pc, exp_pc);
                exp_pc = exp_pc + 8'h04;
            end
            tick();
            n++;
        end
        check("slow_reach8", n < 30, 1'b1);
        tick();
        redirect      = 1'b1;
        redirect_addr = 8'h41;
        tick();
        redirect = 1'b0;
        check("drain_req", imem_req, 1'b1);
        check("drain_addr", imem_addr, 8'h08);
        n = 0;
        while (imem_req && n < 10) begin
            check("drain_hold_addr", imem_addr, 8'h08);
            check("drain_no_valid", id_valid, 1'b0);
            tick();
            n++;
        end
        check("drain_timeout", n < 10, 1'b1);
        check("drain_dropped", id_valid, 1'b0);
        tick();
        check("redir_req", imem_req, 1'b1);
        check("redir_addr", imem_addr, 8'h40);
        n = 0;
        while (!id_valid && n < 10) begin
            tick();
            n++;
        end
        check("redir_valid_timeout", n < 10, 1'b1);
        check("redir_pc", id_pc, 8'h40);
        check("redir_instr", id_instr, word(8'h40));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
